// File: rtl/turn_sequencer.sv
// ---------------------------------------------------------------------------
// turn_sequencer
// ---------------------------------------------------------------------------
// Game-flow controller. It runs one ply at a time:
//   1. pulse gen_en to generateMoves and wait for gen_done,
//   2. hand the move request to the human path (keyboard/LCD confirm)
//      or to AI_Engine, chosen by the colour mask latched at start,
//   3. register the chosen move and pulse bu_en to board_update_v,
//   4. wait for bu_done, count the ply, and either loop or end the game.
// The game ends on: no legal moves (side to move loses), the ply limit
// (draw), or the AI failing to answer within AI_TIMEOUT cycles (side to
// move loses, ai_timeout flagged).
//
// Handshake semantics: every *_done / human_confirm input is a request
// that is only honoured while the FSM sits in the state that owns it
// (gen_done in S_GWAIT, human_confirm in S_HUMAN, ai_done in S_AI,
// bu_done in S_BWAIT). In any other state the input is ignored, so a
// stray or late pulse can never advance the game. gen_en and bu_en are
// single-cycle pulses; ai_en is a level held for the whole S_AI stay.
//
// Ports:
//   clk            system clock (clk50)
//   RST            asynchronous active-high reset
//   start          begin a new game (only in S_IDLE / S_OVER)
//   ai_mask[1:0]   bit p set -> player p is AI (0 white, 1 black)
//   player_in      side to move, from board_update_v
//   gen_en         pulse to generateMoves
//   gen_done       generateMoves finished
//   move_set[127:0] legal-move bitmap, all-zero = no legal move
//   human_confirm  human move confirmed (pulse)
//   human_pid/loc  human piece ID / destination {y,x}
//   ai_en          level enable to AI_Engine
//   ai_done        AI_Engine finished
//   ai_pid/loc     AI piece ID / destination
//   bu_en          pulse to board_update_v
//   bu_pid/loc     registered move handed to board_update_v
//   bu_done        board_update_v finished
//   ply_count[8:0] completed plies in this game
//   game_over      high while in S_OVER
//   draw           game ended on ply limit
//   winner         winning colour when game_over && !draw
//   ai_timeout     game ended because the AI did not answer in time
//   state_dbg[2:0] current state encoding
// ---------------------------------------------------------------------------
module turn_sequencer #(
   parameter int MAX_PLIES  = 200,
   parameter int AI_TIMEOUT = 25000000,
   parameter int TO_W       = 25
) (
   input  logic         clk,
   input  logic         RST,
   input  logic         start,
   input  logic [1:0]   ai_mask,
   input  logic         player_in,
   output logic         gen_en,
   input  logic         gen_done,
   input  logic [127:0] move_set,
   input  logic         human_confirm,
   input  logic [3:0]   human_pid,
   input  logic [5:0]   human_loc,
   output logic         ai_en,
   input  logic         ai_done,
   input  logic [3:0]   ai_pid,
   input  logic [5:0]   ai_loc,
   output logic         bu_en,
   output logic [3:0]   bu_pid,
   output logic [5:0]   bu_loc,
   input  logic         bu_done,
   output logic [8:0]   ply_count,
   output logic         game_over,
   output logic         draw,
   output logic         winner,
   output logic         ai_timeout,
   output logic [2:0]   state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_GEN    = 3'd1,
      S_GWAIT  = 3'd2,
      S_HUMAN  = 3'd3,
      S_AI     = 3'd4,
      S_COMMIT = 3'd5,
      S_BWAIT  = 3'd6,
      S_OVER   = 3'd7
   } state_t;

   // Last counter value allowed in S_AI; reaching it without ai_done
   // ends the game on the following edge.
   localparam logic [TO_W-1:0] TO_LAST   = TO_W'(AI_TIMEOUT - 1);
   localparam logic [8:0]      PLY_LIMIT = 9'(MAX_PLIES);

   state_t          state;
   logic [1:0]      mask_q;
   logic [TO_W-1:0] to_cnt;
   logic [8:0]      ply_next;

   assign ply_next  = ply_count + 9'd1;

   // Level outputs decoded straight from the state register.
   assign ai_en     = (state == S_AI);
   assign game_over = (state == S_OVER);
   assign state_dbg = state;

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state      <= S_IDLE;
         mask_q     <= 2'b00;
         to_cnt     <= '0;
         gen_en     <= 1'b0;
         bu_en      <= 1'b0;
         bu_pid     <= 4'd0;
         bu_loc     <= 6'd0;
         ply_count  <= 9'd0;
         draw       <= 1'b0;
         winner     <= 1'b0;
         ai_timeout <= 1'b0;
      end else begin
         // Pulses default low; they are raised on the edge that enters
         // their owning state so they are high for exactly that state.
         gen_en <= 1'b0;
         bu_en  <= 1'b0;

         case (state)
            S_IDLE, S_OVER: begin
               if (start) begin
                  mask_q     <= ai_mask;
                  ply_count  <= 9'd0;
                  draw       <= 1'b0;
                  winner     <= 1'b0;
                  ai_timeout <= 1'b0;
                  gen_en     <= 1'b1;
                  state      <= S_GEN;
               end
            end

            S_GEN: begin
               state <= S_GWAIT;
            end

            S_GWAIT: begin
               if (gen_done) begin
                  if (move_set == 128'd0) begin
                     // Side to move is stuck: the other side wins.
                     winner <= ~player_in;
                     state  <= S_OVER;
                  end else if (mask_q[player_in]) begin
                     to_cnt <= '0;
                     state  <= S_AI;
                  end else begin
                     state <= S_HUMAN;
                  end
               end
            end

            S_HUMAN: begin
               if (human_confirm) begin
                  bu_pid <= human_pid;
                  bu_loc <= human_loc;
                  bu_en  <= 1'b1;
                  state  <= S_COMMIT;
               end
            end

            S_AI: begin
               // ai_done is checked first so an answer on the final
               // allowed cycle still counts as a move.
               if (ai_done) begin
                  bu_pid <= ai_pid;
                  bu_loc <= ai_loc;
                  bu_en  <= 1'b1;
                  state  <= S_COMMIT;
               end else if (to_cnt == TO_LAST) begin
                  ai_timeout <= 1'b1;
                  winner     <= ~player_in;
                  state      <= S_OVER;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end

            S_COMMIT: begin
               state <= S_BWAIT;
            end

            S_BWAIT: begin
               if (bu_done) begin
                  ply_count <= ply_next;
                  if (ply_next == PLY_LIMIT) begin
                     draw  <= 1'b1;
                     state <= S_OVER;
                  end else begin
                     gen_en <= 1'b1;
                     state  <= S_GEN;
                  end
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer with a short ply limit and timeout.
module tb_turn_sequencer;

   logic         clk;
   logic         RST;
   logic         start;
   logic [1:0]   ai_mask;
   logic         player_in;
   logic         gen_en;
   logic         gen_done;
   logic [127:0] move_set;
   logic         human_confirm;
   logic [3:0]   human_pid;
   logic [5:0]   human_loc;
   logic         ai_en;
   logic         ai_done;
   logic [3:0]   ai_pid;
   logic [5:0]   ai_loc;
   logic         bu_en;
   logic [3:0]   bu_pid;
   logic [5:0]   bu_loc;
   logic         bu_done;
   logic [8:0]   ply_count;
   logic         game_over;
   logic         draw;
   logic         winner;
   logic         ai_timeout;
   logic [2:0]   state_dbg;

   int compared;
   int mismatched;

   // Every output packed together; all-zero after reset.
   logic [28:0] all_out;
   assign all_out = {gen_en, ai_en, bu_en, bu_pid, bu_loc, ply_count,
                     game_over, draw, winner, ai_timeout, state_dbg};

   turn_sequencer #(.MAX_PLIES(2), .AI_TIMEOUT(8), .TO_W(4)) dut (
      .clk(clk), .RST(RST), .start(start), .ai_mask(ai_mask),
      .player_in(player_in), .gen_en(gen_en), .gen_done(gen_done),
      .move_set(move_set), .human_confirm(human_confirm),
      .human_pid(human_pid), .human_loc(human_loc), .ai_en(ai_en),
      .ai_done(ai_done), .ai_pid(ai_pid), .ai_loc(ai_loc), .bu_en(bu_en),
      .bu_pid(bu_pid), .bu_loc(bu_loc), .bu_done(bu_done),
      .ply_count(ply_count), .game_over(game_over), .draw(draw),
      .winner(winner), .ai_timeout(ai_timeout), .state_dbg(state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic pulse_start(input logic [1:0] m);
      ai_mask = m; start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic pulse_gen_done(input logic p, input logic [127:0] ms);
      player_in = p; move_set = ms; gen_done = 1'b1; tick(); gen_done = 1'b0;
   endtask

   task automatic pulse_bu_done();
      bu_done = 1'b1; tick(); bu_done = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      RST = 1'b1;
      #3;
      compared++; if (all_out !== 29'd0) begin mismatched++; $display("FAIL reset_outputs got %h want 0", all_out); end
      #3 RST = 1'b0;
      tick();
      compared++; if (state_dbg !== 3'd0) begin mismatched++; $display("FAIL reset_idle got %0d want 0", state_dbg); end
   endtask

   task automatic test_human_ply();
      pulse_start(2'b00);
      compared++; if (gen_en !== 1'b1 || state_dbg !== 3'd1) begin mismatched++; $display("FAIL hp_gen_en got %0b/%0d want 1/1", gen_en, state_dbg); end
      tick();
      compared++; if (gen_en !== 1'b0 || state_dbg !== 3'd2) begin mismatched++; $display("FAIL hp_gwait got %0b/%0d want 0/2", gen_en, state_dbg); end
      pulse_gen_done(1'b0, 128'd1);
      compared++; if (state_dbg !== 3'd3 || ai_en !== 1'b0) begin mismatched++; $display("FAIL hp_human got %0d/%0b want 3/0", state_dbg, ai_en); end
      human_pid = 4'h3; human_loc = 6'h1C; human_confirm = 1'b1; tick(); human_confirm = 1'b0;
      compared++; if (bu_en !== 1'b1 || bu_pid !== 4'h3 || bu_loc !== 6'h1C) begin mismatched++; $display("FAIL hp_commit got %0b %h %h want 1 3 1c", bu_en, bu_pid, bu_loc); end
      tick();
      compared++; if (bu_en !== 1'b0 || state_dbg !== 3'd6) begin mismatched++; $display("FAIL hp_bwait got %0b/%0d want 0/6", bu_en, state_dbg); end
      pulse_bu_done();
      compared++; if (ply_count !== 9'd1 || gen_en !== 1'b1 || state_dbg !== 3'd1) begin mismatched++; $display("FAIL hp_next got %0d %0b %0d want 1 1 1", ply_count, gen_en, state_dbg); end
   endtask

   task automatic test_draw_and_start_ignored();
      tick();
      pulse_gen_done(1'b1, 128'd5);
      start = 1'b1; tick(); start = 1'b0;
      compared++; if (state_dbg !== 3'd3 || gen_en !== 1'b0 || ply_count !== 9'd1) begin mismatched++; $display("FAIL start_in_human got %0d %0b %0d want 3 0 1", state_dbg, gen_en, ply_count); end
      human_pid = 4'h9; human_loc = 6'h22; human_confirm = 1'b1; tick(); human_confirm = 1'b0;
      tick();
      pulse_bu_done();
      compared++; if (draw !== 1'b1 || ply_count !== 9'd2 || game_over !== 1'b1 || state_dbg !== 3'd7) begin mismatched++; $display("FAIL draw got %0b %0d %0b %0d want 1 2 1 7", draw, ply_count, game_over, state_dbg); end
      compared++; if (gen_en !== 1'b0 || ai_timeout !== 1'b0 || bu_pid !== 4'h9) begin mismatched++; $display("FAIL draw_hold got %0b %0b %h want 0 0 9", gen_en, ai_timeout, bu_pid); end
   endtask

   task automatic test_ai_ply();
      pulse_start(2'b10);
      compared++; if (ply_count !== 9'd0 || draw !== 1'b0 || game_over !== 1'b0 || gen_en !== 1'b1) begin mismatched++; $display("FAIL restart got %0d %0b %0b %0b want 0 0 0 1", ply_count, draw, game_over, gen_en); end
      tick();
      pulse_gen_done(1'b1, 128'h80);
      compared++; if (ai_en !== 1'b1 || state_dbg !== 3'd4) begin mismatched++; $display("FAIL ai_en got %0b/%0d want 1/4", ai_en, state_dbg); end
      tick(); tick();
      ai_pid = 4'hA; ai_loc = 6'h2D; ai_done = 1'b1; tick(); ai_done = 1'b0;
      compared++; if (bu_en !== 1'b1 || bu_pid !== 4'hA || bu_loc !== 6'h2D || ai_en !== 1'b0) begin mismatched++; $display("FAIL ai_commit got %0b %h %h %0b want 1 a 2d 0", bu_en, bu_pid, bu_loc, ai_en); end
      tick();
      pulse_bu_done();
      compared++; if (ply_count !== 9'd1 || state_dbg !== 3'd1) begin mismatched++; $display("FAIL ai_ply_done got %0d/%0d want 1/1", ply_count, state_dbg); end
   endtask

   task automatic test_ai_timeout();
      tick();
      pulse_gen_done(1'b1, 128'd1);
      repeat (7) tick();
      compared++; if (state_dbg !== 3'd4 || ai_timeout !== 1'b0) begin mismatched++; $display("FAIL to_cycle8 got %0d/%0b want 4/0", state_dbg, ai_timeout); end
      tick();
      compared++; if (state_dbg !== 3'd7 || game_over !== 1'b1 || ai_timeout !== 1'b1) begin mismatched++; $display("FAIL to_over got %0d %0b %0b want 7 1 1", state_dbg, game_over, ai_timeout); end
      compared++; if (winner !== 1'b0 || draw !== 1'b0 || ai_en !== 1'b0 || ply_count !== 9'd1) begin mismatched++; $display("FAIL to_flags got %0b %0b %0b %0d want 0 0 0 1", winner, draw, ai_en, ply_count); end
   endtask

   task automatic test_ai_last_cycle();
      pulse_start(2'b11);
      compared++; if (ai_timeout !== 1'b0 || winner !== 1'b0 || ply_count !== 9'd0) begin mismatched++; $display("FAIL restart2 got %0b %0b %0d want 0 0 0", ai_timeout, winner, ply_count); end
      tick();
      pulse_gen_done(1'b0, 128'd1);
      repeat (7) tick();
      // ai_done on the final allowed cycle, with a colliding human_confirm.
      ai_pid = 4'h5; ai_loc = 6'h3F; ai_done = 1'b1;
      human_pid = 4'h1; human_loc = 6'h01; human_confirm = 1'b1;
      tick();
      ai_done = 1'b0; human_confirm = 1'b0;
      compared++; if (state_dbg !== 3'd5 || bu_en !== 1'b1 || ai_timeout !== 1'b0) begin mismatched++; $display("FAIL last_cycle got %0d %0b %0b want 5 1 0", state_dbg, bu_en, ai_timeout); end
      compared++; if (bu_pid !== 4'h5 || bu_loc !== 6'h3F) begin mismatched++; $display("FAIL collide_move got %h %h want 5 3f", bu_pid, bu_loc); end
      tick();
      human_pid = 4'h2; human_confirm = 1'b1; tick(); human_confirm = 1'b0;
      compared++; if (state_dbg !== 3'd6 || bu_pid !== 4'h5) begin mismatched++; $display("FAIL stray_bwait got %0d %h want 6 5", state_dbg, bu_pid); end
      pulse_bu_done();
      compared++; if (ply_count !== 9'd1 || state_dbg !== 3'd1) begin mismatched++; $display("FAIL last_ply got %0d/%0d want 1/1", ply_count, state_dbg); end
   endtask

   task automatic test_no_moves();
      tick();
      pulse_gen_done(1'b0, 128'd0);
      compared++; if (state_dbg !== 3'd7 || game_over !== 1'b1 || winner !== 1'b1 || draw !== 1'b0) begin mismatched++; $display("FAIL nomoves got %0d %0b %0b %0b want 7 1 1 0", state_dbg, game_over, winner, draw); end
      move_set = 128'd1;
      human_confirm = 1'b1; bu_done = 1'b1; ai_done = 1'b1; gen_done = 1'b1;
      tick();
      human_confirm = 1'b0; bu_done = 1'b0; ai_done = 1'b0; gen_done = 1'b0;
      tick();
      compared++; if (state_dbg !== 3'd7 || ply_count !== 9'd1 || bu_en !== 1'b0 || winner !== 1'b1 || gen_en !== 1'b0) begin mismatched++; $display("FAIL over_stray got %0d %0d %0b %0b %0b want 7 1 0 1 0", state_dbg, ply_count, bu_en, winner, gen_en); end
   endtask

   task automatic test_reset_midop();
      pulse_start(2'b00);
      tick();
      pulse_gen_done(1'b0, 128'd1);
      human_pid = 4'h7; human_loc = 6'h15; human_confirm = 1'b1; tick(); human_confirm = 1'b0;
      tick();
      compared++; if (state_dbg !== 3'd6 || bu_pid !== 4'h7) begin mismatched++; $display("FAIL pre_rst_bwait got %0d %h want 6 7", state_dbg, bu_pid); end
      #2 RST = 1'b1;
      #1;
      compared++; if (all_out !== 29'd0) begin mismatched++; $display("FAIL rst_bwait got %h want 0", all_out); end
      #2 RST = 1'b0;
      bu_done = 1'b1; tick(); bu_done = 1'b0;
      compared++; if (state_dbg !== 3'd0 || ply_count !== 9'd0) begin mismatched++; $display("FAIL post_rst_idle got %0d %0d want 0 0", state_dbg, ply_count); end
      pulse_start(2'b01);
      tick();
      pulse_gen_done(1'b0, 128'd1);
      compared++; if (ai_en !== 1'b1) begin mismatched++; $display("FAIL pre_rst_ai got %0b want 1", ai_en); end
      tick();
      #2 RST = 1'b1;
      #1;
      compared++; if (all_out !== 29'd0) begin mismatched++; $display("FAIL rst_ai got %h want 0", all_out); end
      #2 RST = 1'b0;
      ai_done = 1'b1; tick(); ai_done = 1'b0;
      compared++; if (state_dbg !== 3'd0 || bu_en !== 1'b0 || bu_pid !== 4'h0) begin mismatched++; $display("FAIL post_rst_ai got %0d %0b %h want 0 0 0", state_dbg, bu_en, bu_pid); end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      compared = 0;
      mismatched = 0;
      RST = 1'b1; start = 1'b0; ai_mask = 2'b00; player_in = 1'b0;
      gen_done = 1'b0; move_set = 128'd0; human_confirm = 1'b0;
      human_pid = 4'd0; human_loc = 6'd0; ai_done = 1'b0; ai_pid = 4'd0;
      ai_loc = 6'd0; bu_done = 1'b0;

      test_reset();
      test_human_ply();
      test_draw_and_start_ignored();
      test_ai_ply();
      test_ai_timeout();
      test_ai_last_cycle();
      test_no_moves();
      test_reset_midop();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/turn_sequencer.md
Name: turn_sequencer

Overview:
Game-flow controller that sequences board_update_v, generateMoves and the move source (keyboard/LCD human path or AI_Engine) once per ply. After each update it triggers move generation and routes the move request to the human or AI path according to a per-colour mask. It then commits the accepted move to board_update_v and detects end of game: no legal moves, ply limit, or AI timeout. It sits in top_level between the keyboard/LCD confirm logic, AI_Engine and board_update_v.

Parameters:
MAX_PLIES, 200, ply count that ends the game as a draw (1..511)
AI_TIMEOUT, 25000000, max cycles in S_AI before timeout (0.5 s at 50 MHz)
TO_W, 25, width of timeout counter

Ports:
clk  in  1  system clock (clk50)
RST  in  1  asynchronous active-high reset
start  in  1  1-cycle pulse: begin a new game (accepted in S_IDLE or S_OVER only)
ai_mask  in  2  bit[p]=1 means player p is AI (0=white, 1=black); sampled on accepted start
player_in  in  1  side to move, from board_update_v output_player
gen_en  out  1  1-cycle pulse to generateMoves enable
gen_done  in  1  generateMoves done_gm
move_set  in  128  generateMoves moveSet; all-zero means no legal move
human_confirm  in  1  1-cycle pulse: human move confirmed
human_pid  in  4  human piece ID
human_loc  in  6  human destination {y,x}
ai_en  out  1  level enable to AI_Engine, held while in S_AI
ai_done  in  1  AI_Engine done
ai_pid  in  4  AI piece_to_move
ai_loc  in  6  AI output_move
bu_en  out  1  1-cycle pulse to board_update_v en
bu_pid  out  4  registered piece ID for board_update_v
bu_loc  out  6  registered destination for board_update_v
bu_done  in  1  board_update_v done
ply_count  out  9  completed plies this game
game_over  out  1  high in S_OVER
draw  out  1  valid with game_over: ply limit reached
winner  out  1  valid with game_over && !draw
ai_timeout  out  1  sticky: game ended by AI timeout
state_dbg  out  3  current state encoding

Behaviour:
- Reset (async, RST=1): state S_IDLE. All outputs 0, including bu_pid/bu_loc, ply_count and the internal ai_mask register.
- States and encodings: S_IDLE=0, S_GEN=1, S_GWAIT=2, S_HUMAN=3, S_AI=4, S_COMMIT=5, S_BWAIT=6, S_OVER=7.
- S_IDLE/S_OVER + start: latch ai_mask. Clear ply_count, draw, winner, ai_timeout, game_over. Go to S_GEN.
- S_GEN: gen_en=1 for this cycle only. Always go to S_GWAIT next cycle.
- S_GWAIT, on gen_done:
  - move_set==0: go to S_OVER, winner=~player_in.
  - else if mask[player_in]=1: go to S_AI and clear the timeout counter.
  - else: go to S_HUMAN.
- S_HUMAN, on human_confirm: register bu_pid/bu_loc from human_pid/human_loc, go to S_COMMIT.
- S_AI:
  - ai_en=1 combinationally from state; counter increments each cycle.
  - On ai_done: register ai_pid/ai_loc into bu_pid/bu_loc, go to S_COMMIT.
  - Otherwise, when counter==AI_TIMEOUT-1: go to S_OVER with ai_timeout=1 and winner=~player_in.
  - ai_done on the same cycle as the timeout: ai_done wins.
- S_COMMIT: bu_en=1 for this cycle only. bu_pid/bu_loc stay stable from S_COMMIT until the next accepted move. Next state S_BWAIT.
- S_BWAIT, on bu_done: ply_count+1.
  - New value == MAX_PLIES: go to S_OVER with draw=1.
  - Else go to S_GEN.
- Latency: start to gen_en = 1 cycle. Accepting edge to bu_en = 1 cycle. bu_done to next gen_en = 1 cycle.
- Ignored inputs:
  - Any handshake input outside its owning state (gen_done, human_confirm, ai_done, bu_done).
  - start outside S_IDLE/S_OVER.
  - human_confirm and ai_done arriving together: only the one matching the current state counts.
- ply_count never exceeds MAX_PLIES. The game always ends at MAX_PLIES.
- game_over=1 exactly when state==S_OVER. Outputs hold in S_OVER until start or RST.
- RST mid-operation: immediate return to reset values. In-flight pulses are dropped and no partial commit occurs.

Test Plan:
- Reset, ai_mask=2'b00, start, gen_done with move_set=1 → gen_en one cycle after start. Human: pid=4'h3, loc=6'h1C, confirm → bu_en one cycle later with bu_pid=3, bu_loc=0x1C. bu_done → ply_count=1, gen_en next cycle.
- ai_mask=2'b10, player_in=1 at gen_done → ai_en=1. ai_done with pid=4'hA, loc=6'h2D → bu_en pulse with bu_pid=A, bu_loc=0x2D, ai_en=0.
- AI_TIMEOUT=8, ai_done never asserted → game_over=1 and ai_timeout=1 after 8 cycles in S_AI, winner=~player_in. ai_done at cycle 8 instead → no timeout, commit.
- gen_done with move_set=0, player_in=0 → S_OVER, game_over=1, draw=0, winner=1. Stray human_confirm/bu_done in S_OVER → no change.
- MAX_PLIES=2 → after 2nd bu_done: draw=1, ply_count=2. A new start clears ply_count/draw and pulses gen_en.
- RST asserted in S_BWAIT and in S_AI → all outputs 0 asynchronously. start ignored while in S_HUMAN.
